adc_clk_monitor: RTL and testbench

Qualifies the ADC clock PLL before the ADC datapath is released from reset. Running on the 50 MHz reference clock, it sequences the PLL reset, waits for a stable `locked`, and measures the 2 MHz ADC sample clock against a fixed gate window. Once the clock is confirmed, it asserts `clk_good` and releases the downstream ADC reset. It sits between the PLL wrapper's reset/locked/outclk_0 pins and the ADC capture logic. On loss of lock or frequency error it retries the PLL a bounded number of times, then latches a fault.

---
 rtl/adc_clk_monitor.sv | 198 +++++++++++++++++++
 tb/tb_adc_clk_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_clk_monitor.sv
// ADC clock qualifier: sequences the PLL reset, waits for a stable lock, then
// counts mon_clk edges per gate window before releasing the ADC datapath reset.
`timescale 1ns/1ps
module adc_clk_monitor #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int GATE_CYCLES  = 1000,
  parameter int EXP_EDGES    = 40,
  parameter int TOL          = 1,
  parameter int GOOD_WINDOWS = 4,
  parameter int MAX_RETRY    = 3,
  parameter int ADC_RST_DLY  = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       mon_clk,
  input  logic       fault_clr,
  output logic       pll_rst,
  output logic       clk_good,
  output logic       adc_rst_n,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] edge_count
);

  localparam int PH_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int STB_W  = $clog2(LOCK_STABLE + 1);
  localparam int WIN_W  = $clog2(GATE_CYCLES);
  localparam int GW_W   = $clog2(GOOD_WINDOWS + 1);
  localparam int DLY_W  = $clog2(ADC_RST_DLY + 1);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, MEASURE, RUN, FAULT} state_t;

  state_t             state, state_next;
  logic               locked_p0, locked_p1;
  logic               mon_p0, mon_p1, mon_p2;
  logic               edge_pulse;
  logic [PH_W-1:0]    ph_cnt, ph_next;
  logic [STB_W-1:0]   stb_cnt, stb_next;
  logic [GW_W-1:0]    gw_cnt, gw_next;
  logic [WIN_W-1:0]   win_cnt;
  logic [7:0]         edge_acc, win_total;
  logic               win_tc, win_ok, retry_evt;
  logic [3:0]         retry_next;
  logic [DLY_W-1:0]   dly_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] acc, input logic inc);
    return (acc == 8'hFF) ? acc : acc + {7'd0, inc};
  endfunction

  function automatic logic win_pass(input logic [7:0] cnt);
    logic signed [8:0] diff, mag;
    diff = $signed({1'b0, cnt}) - $signed(9'(EXP_EDGES));
    mag  = (diff < 0) ? -diff : diff;
    return mag <= $signed(9'(TOL));
  endfunction

  // Stage p0/p1: synchronizers; p2 on mon_clk gives the rising-edge pulse
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      locked_p0 <= 1'b0;
      locked_p1 <= 1'b0;
      mon_p0    <= 1'b0;
      mon_p1    <= 1'b0;
      mon_p2    <= 1'b0;
    end else begin
      locked_p0 <= pll_locked;
      locked_p1 <= locked_p0;
      mon_p0    <= mon_clk;
      mon_p1    <= mon_p0;
      mon_p2    <= mon_p1;
    end
  end

  assign edge_pulse = mon_p1 & ~mon_p2;
  assign win_tc     = (win_cnt == WIN_W'(GATE_CYCLES - 1));
  assign win_total  = sat_inc(edge_acc, edge_pulse);
  assign win_ok     = win_pass(win_total);

  // Gate window only runs while measuring; an edge on the terminal cycle closes with it
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      edge_acc   <= '0;
      edge_count <= '0;
    end else if (state != MEASURE && state != RUN) begin
      win_cnt  <= '0;
      edge_acc <= '0;
    end else if (win_tc) begin
      win_cnt    <= '0;
      edge_acc   <= '0;
      edge_count <= win_total;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      edge_acc <= win_total;
    end
  end

  always_comb begin
    state_next = state;
    ph_next    = ph_cnt + PH_W'(1);
    stb_next   = '0;
    gw_next    = gw_cnt;
    retry_next = retry_count;
    retry_evt  = 1'b0;
    case (state)
      RESET_PLL: begin
        if (ph_cnt == PH_W'(RST_CYCLES - 1)) begin
          state_next = WAIT_LOCK;
          ph_next    = '0;
        end
      end
      WAIT_LOCK: begin
        stb_next = locked_p1 ? stb_cnt + STB_W'(1) : '0;
        if (locked_p1 && stb_cnt == STB_W'(LOCK_STABLE - 1)) begin
          state_next = MEASURE;
          gw_next    = '0;
          ph_next    = '0;
        end else if (ph_cnt == PH_W'(LOCK_TIMEOUT - 1)) begin
          retry_evt = 1'b1;
        end
      end
      MEASURE: begin
        ph_next = '0;
        if (!locked_p1 || (win_tc && !win_ok)) begin
          retry_evt = 1'b1;
        end else if (win_tc) begin
          gw_next = gw_cnt + GW_W'(1);
          if (gw_cnt == GW_W'(GOOD_WINDOWS - 1)) state_next = RUN;
        end
      end
      RUN: begin
        ph_next = '0;
        if (!locked_p1 || (win_tc && !win_ok)) retry_evt = 1'b1;
      end
      FAULT: begin
        ph_next = '0;
        if (fault_clr) begin
          state_next = RESET_PLL;
          retry_next = '0;
        end
      end
      default: state_next = RESET_PLL;
    endcase
    // Lock loss and a bad window in the same cycle collapse into one retry
    if (retry_evt) begin
      ph_next = '0;
      if (retry_count < 4'(MAX_RETRY)) begin
        retry_next = retry_count + 4'd1;
        state_next = RESET_PLL;
      end else begin
        state_next = FAULT;
      end
    end
    if (state_next == RUN) retry_next = '0;
  end

  // Outputs are registered from the next state so they move with the state edge
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_PLL;
      ph_cnt      <= '0;
      stb_cnt     <= '0;
      gw_cnt      <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      clk_good    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      ph_cnt      <= ph_next;
      stb_cnt     <= stb_next;
      gw_cnt      <= gw_next;
      retry_count <= retry_next;
      pll_rst     <= (state_next == RESET_PLL) || (state_next == FAULT);
      clk_good    <= (state_next == RUN);
      fault       <= (state_next == FAULT);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt   <= '0;
      adc_rst_n <= 1'b0;
    end else if (state_next != RUN || !clk_good) begin
      dly_cnt   <= '0;
      adc_rst_n <= 1'b0;
    end else if (dly_cnt == DLY_W'(ADC_RST_DLY - 1)) begin
      adc_rst_n <= 1'b1;
    end else begin
      dly_cnt <= dly_cnt + DLY_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_clk_monitor.sv
// Bench for adc_clk_monitor: mon_clk comes from a mod-1000 phase accumulator so
// every 1000-cycle gate window sees exactly mon_edges rising edges.
`timescale 1ns/1ps
module tb_adc_clk_monitor;

  localparam int TIMEOUT = 2000;

  logic       refclk = 1'b0;
  logic       rst_n, pll_locked, fault_clr;
  logic       mon_clk = 1'b0;
  logic       pll_rst, clk_good, adc_rst_n, fault;
  logic [3:0] retry_count;
  logic [7:0] edge_count;

  int mon_edges = 40;
  int phase = 0;
  int cyc = 0;
  int cyc0 = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct { string tag; int exp; } exp_t;
  exp_t sb[$];

  adc_clk_monitor #(.LOCK_TIMEOUT(TIMEOUT)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .mon_clk(mon_clk),
    .fault_clr(fault_clr), .pll_rst(pll_rst), .clk_good(clk_good),
    .adc_rst_n(adc_rst_n), .fault(fault), .retry_count(retry_count),
    .edge_count(edge_count)
  );

  always #10 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  always @(negedge refclk) begin
    phase   = (phase + mon_edges) % 1000;
    mon_clk = (phase < 500);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int got);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL sb_underflow: got %0d, expected nothing queued", got);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, got, e.exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return clk_good;
      1: return pll_rst;
      2: return fault;
      default: return adc_rst_n;
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic val, input int budget, input string tag);
    int n = 0;
    while (sig(sel) !== val && n < budget) begin
      @(negedge refclk);
      n++;
    end
    check_val(tag, int'(sig(sel)), int'(val));
  endtask

  task automatic release_rst();
    @(negedge refclk);
    rst_n = 1'b1;
    cyc0  = cyc;
  endtask

  task automatic pulse_len(input string tag);
    int n = 0;
    while (pll_rst && n < 100) begin
      @(negedge refclk);
      n++;
    end
    check_val(tag, n, 16);
  endtask

  initial begin
    #1600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t;
    rst_n = 1'b0; pll_locked = 1'b0; fault_clr = 1'b0;
    repeat (3) @(negedge refclk);
    check_val("rst_pll_rst", int'(pll_rst), 1);
    check_val("rst_clk_good", int'(clk_good), 0);
    check_val("rst_adc_rst_n", int'(adc_rst_n), 0);
    check_val("rst_fault", int'(fault), 0);
    check_val("rst_retry", int'(retry_count), 0);
    check_val("rst_edges", int'(edge_count), 0);

    // Nominal bring-up, lock arrives 100 cycles after reset release
    push("nom_edges", 40);
    push("nom_retry", 0);
    release_rst();
    repeat (100) @(negedge refclk);
    pll_locked = 1'b1;
    wait_until(0, 1'b1, 6000, "nom_clk_good");
    lat = cyc - cyc0;
    check_val("nom_lat_in_range", int'(lat >= 5122 && lat <= 5146), 1);
    pop_check(edge_count);
    pop_check(retry_count);
    t = cyc;
    wait_until(3, 1'b1, 20, "nom_adc_rst_n");
    check_val("nom_adc_dly", cyc - t, 8);
    check_val("nom_pll_rst", int'(pll_rst), 0);

    // One-cycle lock glitch in RUN
    repeat (300) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    check_val("glitch_hold_good", int'(clk_good), 1);
    @(negedge refclk);
    check_val("glitch_clk_good", int'(clk_good), 0);
    check_val("glitch_adc_rst_n", int'(adc_rst_n), 0);
    check_val("glitch_pll_rst", int'(pll_rst), 1);
    check_val("glitch_retry", int'(retry_count), 1);
    push("recover_edges", 40);
    push("recover_retry", 0);
    wait_until(0, 1'b1, 6000, "recover_clk_good");
    pop_check(edge_count);
    pop_check(retry_count);

    // Async reset in RUN drops outputs without a clock edge
    repeat (20) @(negedge refclk);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_run_clk_good", int'(clk_good), 0);
    check_val("arst_run_adc_rst_n", int'(adc_rst_n), 0);
    check_val("arst_run_pll_rst", int'(pll_rst), 1);
    check_val("arst_run_edges", int'(edge_count), 0);

    // 41 edges per window is within tolerance
    mon_edges = 41;
    push("tol41_edges", 41);
    push("tol41_retry", 0);
    repeat (3) @(negedge refclk);
    release_rst();
    wait_until(0, 1'b1, 5200, "tol41_clk_good");
    pop_check(edge_count);
    pop_check(retry_count);

    // 42 edges per window fails the first window
    rst_n = 1'b0;
    mon_edges = 42;
    push("tol42_edges", 42);
    push("tol42_retry", 1);
    repeat (3) @(negedge refclk);
    release_rst();
    wait_until(1, 1'b0, 40, "tol42_pll_release");
    wait_until(1, 1'b1, 2200, "tol42_pll_reassert");
    pop_check(edge_count);
    pop_check(retry_count);
    check_val("tol42_clk_good", int'(clk_good), 0);
    pulse_len("tol42_pll_pulse");

    // Lock never arrives: retries exhaust into FAULT
    rst_n = 1'b0;
    pll_locked = 1'b0;
    mon_edges = 40;
    push("exh_retry", 3);
    repeat (3) @(negedge refclk);
    release_rst();
    wait_until(2, 1'b1, 9000, "exh_fault");
    pop_check(retry_count);
    check_val("exh_pll_rst", int'(pll_rst), 1);
    repeat (50) @(negedge refclk);
    check_val("exh_fault_sticky", int'(fault), 1);
    check_val("exh_pll_rst_held", int'(pll_rst), 1);
    fault_clr = 1'b1;
    @(negedge refclk);
    fault_clr = 1'b0;
    check_val("clr_fault", int'(fault), 0);
    check_val("clr_retry", int'(retry_count), 0);
    check_val("clr_pll_rst", int'(pll_rst), 1);
    pulse_len("clr_pll_pulse");

    // 250 edges (refclk/4) and a stuck clock both fail the first window
    rst_n = 1'b0;
    pll_locked = 1'b1;
    mon_edges = 250;
    push("sat_edges", 250);
    push("sat_retry", 1);
    repeat (3) @(negedge refclk);
    release_rst();
    wait_until(1, 1'b0, 40, "sat_pll_release");
    wait_until(1, 1'b1, 2200, "sat_pll_reassert");
    pop_check(edge_count);
    pop_check(retry_count);

    rst_n = 1'b0;
    mon_edges = 0;
    push("stuck_edges", 0);
    push("stuck_retry", 1);
    repeat (3) @(negedge refclk);
    release_rst();
    wait_until(1, 1'b0, 40, "stuck_pll_release");
    wait_until(1, 1'b1, 2200, "stuck_pll_reassert");
    pop_check(edge_count);
    pop_check(retry_count);

    // Async reset at cycle 500 of the second MEASURE window, then full restart
    rst_n = 1'b0;
    mon_edges = 40;
    repeat (3) @(negedge refclk);
    release_rst();
    repeat (2540) @(negedge refclk);
    check_val("meas_edges", int'(edge_count), 40);
    check_val("meas_pll_rst", int'(pll_rst), 0);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_meas_pll_rst", int'(pll_rst), 1);
    check_val("arst_meas_edges", int'(edge_count), 0);
    check_val("arst_meas_retry", int'(retry_count), 0);
    repeat (2) @(negedge refclk);
    release_rst();
    wait_until(0, 1'b1, 5200, "restart_clk_good");
    lat = cyc - cyc0;
    check_val("restart_lat_in_range", int'(lat >= 5038 && lat <= 5046), 1);

    check_val("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
